fetch_queue: RTL and testbench

- Decoupling instruction queue directly downstream of the fetch stage, in front of decode.
- Captures {instruction, pc, tag} triples produced by fetch and instruction memory; presents them in order to decode with a valid/ready handshake.
- Discards stale-tag entries (wrong-path fetches after jump/trap/mret) and supports a full flush.
- Lets fetch run ahead while decode stalls.

---
 rtl/fetch_queue_pkg.sv | 15 +
 rtl/fetch_queue.sv | 116 +++++++++++
 tb/tb_fetch_queue.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the fetch-to-decode instruction queue.
// fetch_entry_t is the default-width entry used by fetch and decode.
package fetch_queue_pkg;

    localparam int          FQ_TAG_W    = 3;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
    localparam logic [FQ_TAG_W-1:0] INVALID_TAG = '1;

    typedef struct packed {
        logic [31:0]         instruction;
        logic [31:0]         pc;
        logic [FQ_TAG_W-1:0] tag;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Purpose: in-order {instruction, pc, tag} queue between fetch and decode; drops stale-tag heads, supports flush.
// Latency: 1 cycle push-to-pop; 0 cycles when empty if FETCH_QUEUE_BYPASS_EN is defined (bypass on tag match).
// Backpressure: push_ready = !full from registered state only; head waits for pop_ready, stale heads drain one per cycle.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 3
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush_i,
    input  logic [TAG_W-1:0]         expected_tag_i,
    input  logic                     push_valid_i,
    output logic                     push_ready_o,
    input  logic [31:0]              instruction_i,
    input  logic [31:0]              pc_i,
    input  logic [TAG_W-1:0]         tag_i,
    output logic                     pop_valid_o,
    input  logic                     pop_ready_i,
    output logic [31:0]              instruction_o,
    output logic [31:0]              pc_o,
    output logic [TAG_W-1:0]         tag_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    // Local entry type so TAG_W can differ from the package default.
    typedef struct packed {
        logic [31:0]      instruction;
        logic [31:0]      pc;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    entry_t          head;
    entry_t          push_entry;

    logic empty;
    logic full;
    logic head_ok;
    logic push_fire;
    logic pop_fire;
    logic drop_fire;
    logic bypass;
    logic bypass_take;
    logic write_en;

    assign empty   = (rd_ptr == wr_ptr);
    assign full    = (rd_ptr[IW-1:0] == wr_ptr[IW-1:0]) && (rd_ptr[IW] != wr_ptr[IW]);
    assign head    = mem[rd_ptr[IW-1:0]];
    assign head_ok = !empty && (head.tag == expected_tag_i);

    assign push_entry = '{instruction: instruction_i, pc: pc_i, tag: tag_i};

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = empty && push_valid_i && (tag_i == expected_tag_i) && !flush_i;
`else
    assign bypass = 1'b0;
`endif

    assign push_ready_o = !full;
    assign push_fire    = push_valid_i && push_ready_o && !flush_i;
    assign pop_valid_o  = (head_ok || bypass) && !flush_i;
    assign pop_fire     = head_ok && pop_ready_i && !flush_i;
    assign drop_fire    = !empty && !head_ok && !flush_i;
    // A bypassed entry consumed in the same cycle never touches storage.
    assign bypass_take  = bypass && pop_ready_i;
    assign write_en     = push_fire && !bypass_take;

    assign level_o = wr_ptr - rd_ptr;

    always_comb begin
        instruction_o = NOP_INSTR;
        pc_o          = '0;
        tag_o         = {TAG_W{1'b1}};
        if (bypass) begin
            instruction_o = instruction_i;
            pc_o          = pc_i;
            tag_o         = tag_i;
        end else if (!empty) begin
            instruction_o = head.instruction;
            pc_o          = head.pc;
            tag_o         = head.tag;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (write_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_fire || drop_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: contents are only observed between the pointers.
    always_ff @(posedge clk) begin
        if (write_en) begin
            mem[wr_ptr[IW-1:0]] <= push_entry;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: expected pops go into a scoreboard queue,
// a negedge monitor compares every pop handshake against it.
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int TAG_W = 3;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              flush_i;
    logic [TAG_W-1:0]  expected_tag_i;
    logic              push_valid_i;
    logic              push_ready_o;
    logic [31:0]       instruction_i;
    logic [31:0]       pc_i;
    logic [TAG_W-1:0]  tag_i;
    logic              pop_valid_o;
    logic              pop_ready_i;
    logic [31:0]       instruction_o;
    logic [31:0]       pc_o;
    logic [TAG_W-1:0]  tag_o;
    logic [2:0]        level_o;

    typedef struct packed {
        logic [31:0]      instr;
        logic [31:0]      pc;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t expq [$];
    int   checks = 0;
    int   errors = 0;

    fetch_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .flush_i        (flush_i),
        .expected_tag_i (expected_tag_i),
        .push_valid_i   (push_valid_i),
        .push_ready_o   (push_ready_o),
        .instruction_i  (instruction_i),
        .pc_i           (pc_i),
        .tag_i          (tag_i),
        .pop_valid_o    (pop_valid_o),
        .pop_ready_i    (pop_ready_i),
        .instruction_o  (instruction_o),
        .pc_o           (pc_o),
        .tag_o          (tag_o),
        .level_o        (level_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return 32'hC0DE_0000 ^ pc;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_push(input logic v, input logic [31:0] pc, input logic [TAG_W-1:0] tag, input logic expect_pop);
        push_valid_i  = v;
        pc_i          = pc;
        instruction_i = instr_of(pc);
        tag_i         = tag;
        if (v && expect_pop) expq.push_back('{instr: instr_of(pc), pc: pc, tag: tag});
    endtask

    // Monitor: every pop handshake must match the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n && pop_valid_o && pop_ready_i) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pop: got pc %h expected no pop", pc_o);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    check("pop_pc", pc_o, e.pc);
                    check("pop_instr", instruction_o, e.instr);
                    check("pop_tag", 32'(tag_o), 32'(e.tag));
                end
            end
        end
    end

    initial begin
        reset_n        = 1'b0;
        flush_i        = 1'b0;
        expected_tag_i = '0;
        pop_ready_i    = 1'b0;
        drive_push(1'b0, 32'h0, '0, 1'b0);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_push_ready", 32'(push_ready_o), 32'd1);
        check("rst_pop_valid", 32'(pop_valid_o), 32'd0);
        check("rst_level", 32'(level_o), 32'd0);
        check("rst_instr", instruction_o, NOP);
        check("rst_pc", pc_o, 32'd0);
        check("rst_tag", 32'(tag_o), 32'd7);
        tick();
        reset_n = 1'b1;

        // Fill to full with decode stalled, then a refused 5th push
        for (int i = 0; i < 4; i++) begin
            drive_push(1'b1, 32'(4 * i), 3'd0, 1'b1);
            tick();
        end
        drive_push(1'b1, 32'h100, 3'd0, 1'b0);
        @(negedge clk);
        check("full_level", 32'(level_o), 32'd4);
        check("full_push_ready", 32'(push_ready_o), 32'd0);
        tick();
        drive_push(1'b0, 32'h0, 3'd0, 1'b0);
        @(negedge clk);
        check("refused_level", 32'(level_o), 32'd4);

        // Drain in order
        tick();
        pop_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("drain_level", 32'(level_o), 32'(4 - i));
            tick();
        end
        @(negedge clk);
        check("drained_pop_valid", 32'(pop_valid_o), 32'd0);
        check("drained_instr", instruction_o, NOP);
        check("drained_pc", pc_o, 32'd0);
        check("drained_tag", 32'(tag_o), 32'd7);
        check("drained_level", 32'(level_o), 32'd0);

        // Stale-tag drop: pc 10/14 tag 0 dropped, pc 40 tag 1 popped
        tick();
        pop_ready_i = 1'b0;
        drive_push(1'b1, 32'h10, 3'd0, 1'b0);
        tick();
        drive_push(1'b1, 32'h14, 3'd0, 1'b0);
        tick();
        expected_tag_i = 3'd1;
        pop_ready_i    = 1'b1;
        drive_push(1'b1, 32'h40, 3'd1, 1'b1);
        @(negedge clk);
        check("stale1_pop_valid", 32'(pop_valid_o), 32'd0);
        check("stale1_pc", pc_o, 32'h10);
        tick();
        drive_push(1'b0, 32'h0, 3'd0, 1'b0);
        @(negedge clk);
        check("stale2_pop_valid", 32'(pop_valid_o), 32'd0);
        check("stale2_level", 32'(level_o), 32'd2);
        tick();
        @(negedge clk);
        check("tag1_pop_valid", 32'(pop_valid_o), 32'd1);
        check("tag1_level", 32'(level_o), 32'd1);
        tick();
        @(negedge clk);
        check("after_tag1_level", 32'(level_o), 32'd0);

        // Flush with 3 entries held and a push in the flush cycle
        tick();
        pop_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_push(1'b1, 32'h50 + 32'(4 * i), 3'd1, 1'b0);
            tick();
        end
        flush_i = 1'b1;
        drive_push(1'b1, 32'h20, 3'd1, 1'b0);
        @(negedge clk);
        check("flush_level_before", 32'(level_o), 32'd3);
        check("flush_pop_valid", 32'(pop_valid_o), 32'd0);
        tick();
        flush_i     = 1'b0;
        pop_ready_i = 1'b1;
        drive_push(1'b0, 32'h0, 3'd1, 1'b0);
        @(negedge clk);
        check("flush_level_after", 32'(level_o), 32'd0);
        check("flush_pop_valid_after", 32'(pop_valid_o), 32'd0);
        check("flush_pc_after", pc_o, 32'd0);

        // Streaming 10 entries with pointer wrap
        tick();
        for (int k = 0; k < 10; k++) begin
            drive_push(1'b1, 32'(4 * k), 3'd1, 1'b1);
            if (k > 0) begin
                @(negedge clk);
`ifdef FETCH_QUEUE_BYPASS_EN
                check("stream_level", 32'(level_o), 32'd0);
`else
                check("stream_level", 32'(level_o), 32'd1);
`endif
            end
            tick();
        end
        drive_push(1'b0, 32'h0, 3'd1, 1'b0);
        repeat (2) tick();
        @(negedge clk);
        check("stream_end_level", 32'(level_o), 32'd0);

        // Empty-queue push with matching tag and decode ready
        tick();
        drive_push(1'b1, 32'h80, 3'd1, 1'b1);
        @(negedge clk);
`ifdef FETCH_QUEUE_BYPASS_EN
        check("byp_same_valid", 32'(pop_valid_o), 32'd1);
        check("byp_same_pc", pc_o, 32'h80);
        check("byp_same_level", 32'(level_o), 32'd0);
`else
        check("byp_same_valid", 32'(pop_valid_o), 32'd0);
        check("byp_same_level", 32'(level_o), 32'd0);
`endif
        tick();
        drive_push(1'b0, 32'h0, 3'd1, 1'b0);
        @(negedge clk);
`ifdef FETCH_QUEUE_BYPASS_EN
        check("byp_next_valid", 32'(pop_valid_o), 32'd0);
        check("byp_next_level", 32'(level_o), 32'd0);
`else
        check("byp_next_valid", 32'(pop_valid_o), 32'd1);
        check("byp_next_pc", pc_o, 32'h80);
        check("byp_next_level", 32'(level_o), 32'd1);
`endif
        repeat (2) tick();

        check("scoreboard_empty", 32'(expq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
